// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - operand/result bundle between the control unit and div_unit
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic              div_start;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  logic              div_done;
  logic              div_zero;

  modport master (
    output div_start, dividend, divisor,
    input  hi_out, lo_out, busy, div_done, div_zero
  );

  modport slave (
    input  div_start, dividend, divisor,
    output hi_out, lo_out, busy, div_done, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider, quotient to LO and remainder to HI
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_unit_if.slave   io_div
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [5:0]          r_cnt;
  logic [DATA_W:0]     r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_dsr;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_sign_q;
  logic                r_sign_r;
  logic                r_done;
  logic                r_zero;

  logic                w_accept;
  logic                w_zero_req;
  logic                w_last;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic                w_neg;
  logic [DATA_W:0]     w_rem_next;
  logic [DATA_W-1:0]   w_quo_next;
  logic [DATA_W-1:0]   w_abs_dvd;
  logic [DATA_W-1:0]   w_abs_dsr;
  logic [DATA_W-1:0]   w_q_signed;
  logic [DATA_W-1:0]   w_r_signed;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_req   = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_div.div_start) begin
          if (io_div.divisor == '0) begin
            w_zero_req = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == 6'd31) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Magnitudes are unsigned, so 0x80000000 maps onto itself without overflow.
  assign w_abs_dvd = io_div.dividend[DATA_W-1] ? -io_div.dividend : io_div.dividend;
  assign w_abs_dsr = io_div.divisor[DATA_W-1]  ? -io_div.divisor  : io_div.divisor;

  // r_quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in.
  assign w_shift    = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_dsr};
  assign w_neg      = w_diff[DATA_W];
  assign w_rem_next = w_neg ? w_shift : w_diff;
  assign w_quo_next = {r_quo[DATA_W-2:0], ~w_neg};
  assign w_q_signed = r_sign_q ? -w_quo_next : w_quo_next;
  assign w_r_signed = r_sign_r ? -w_rem_next[DATA_W-1:0] : w_rem_next[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      r_zero  <= w_zero_req;
      if (w_accept) begin
        r_rem    <= '0;
        r_cnt    <= '0;
        r_quo    <= w_abs_dvd;
        r_dsr    <= w_abs_dsr;
        r_sign_q <= io_div.dividend[DATA_W-1] ^ io_div.divisor[DATA_W-1];
        r_sign_r <= io_div.dividend[DATA_W-1];
      end else if (r_state == S_RUN) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) begin
          r_hi <= w_r_signed;
          r_lo <= w_q_signed;
        end
      end
    end
  end

  assign io_div.busy     = (r_state == S_RUN);
  assign io_div.div_done = r_done;
  assign io_div.div_zero = r_zero;
  assign io_div.hi_out   = r_hi;
  assign io_div.lo_out   = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) io();

  div_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_div (io)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    io.div_start = 1'b1;
    io.dividend  = a;
    io.divisor   = b;
    @(negedge clk);
    io.div_start = 1'b0;
    io.dividend  = $urandom();
    io.divisor   = $urandom();
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!io.div_done && lat < 100) begin
      if (io.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io.div_start = 1'b1;
    io.dividend = 32'd7;
    io.divisor = 32'd2;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    io.div_start = 1'b0;
    n_cmp++; if (io.hi_out !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", io.hi_out); end
    n_cmp++; if (io.lo_out !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", io.lo_out); end
    n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", io.busy); end
    n_cmp++; if (io.div_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", io.div_done); end
    n_cmp++; if (io.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", io.div_zero); end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [63:0] e;
    sb_q.push_back({32'd1, 32'd3});
    start_op(32'd7, 32'd2);
    wait_done(lat, bc);
    pop_exp(e);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL basic_latency: got %0d want 32", lat); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", io.busy); end
    n_cmp++; if (io.lo_out !== e[31:0]) begin n_bad++; $display("FAIL basic_lo: got %h want %h", io.lo_out, e[31:0]); end
    n_cmp++; if (io.hi_out !== e[63:32]) begin n_bad++; $display("FAIL basic_hi: got %h want %h", io.hi_out, e[63:32]); end
    @(negedge clk);
    n_cmp++; if (io.div_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", io.div_done); end
  endtask

  task automatic test_signs();
    logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] tb [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] th [3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] tl [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    int lat, bc;
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({th[i], tl[i]});
      start_op(ta[i], tb[i]);
      wait_done(lat, bc);
      pop_exp(e);
      n_cmp++; if (io.lo_out !== e[31:0]) begin n_bad++; $display("FAIL signs_lo[%0d]: got %h want %h", i, io.lo_out, e[31:0]); end
      n_cmp++; if (io.hi_out !== e[63:32]) begin n_bad++; $display("FAIL signs_hi[%0d]: got %h want %h", i, io.hi_out, e[63:32]); end
    end
  endtask

  task automatic test_corners();
    logic [31:0] ta [3] = '{32'h8000_0000, 32'd0, 32'd5};
    logic [31:0] tb [3] = '{32'hFFFF_FFFF, 32'd5, 32'd7};
    logic [31:0] th [3] = '{32'd0, 32'd0, 32'd5};
    logic [31:0] tl [3] = '{32'h8000_0000, 32'd0, 32'd0};
    int lat, bc;
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({th[i], tl[i]});
      start_op(ta[i], tb[i]);
      wait_done(lat, bc);
      pop_exp(e);
      n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL corners_latency[%0d]: got %0d want 32", i, lat); end
      n_cmp++; if (io.lo_out !== e[31:0]) begin n_bad++; $display("FAIL corners_lo[%0d]: got %h want %h", i, io.lo_out, e[31:0]); end
      n_cmp++; if (io.hi_out !== e[63:32]) begin n_bad++; $display("FAIL corners_hi[%0d]: got %h want %h", i, io.hi_out, e[63:32]); end
      n_cmp++; if (io.div_zero !== 1'b0) begin n_bad++; $display("FAIL corners_zero_flag[%0d]: got %b want 0", i, io.div_zero); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, dones, zeros;
    logic [63:0] e;
    sb_q.push_back({32'd1, 32'd3});
    start_op(32'd7, 32'd2);
    wait_done(lat, bc);
    pop_exp(e);
    n_cmp++; if ({io.hi_out, io.lo_out} !== e) begin n_bad++; $display("FAIL dz_prior: got %h want %h", {io.hi_out, io.lo_out}, e); end
    @(negedge clk);
    start_op(32'd9, 32'd0);
    n_cmp++; if (io.div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_pulse: got %b want 1", io.div_zero); end
    n_cmp++; if (io.div_done !== 1'b0) begin n_bad++; $display("FAIL dz_done_with_zero: got %b want 0", io.div_done); end
    n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy: got %b want 0", io.busy); end
    dones = 0;
    zeros = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.div_done) dones++;
      if (io.div_zero) zeros++;
    end
    n_cmp++; if (zeros !== 0) begin n_bad++; $display("FAIL dz_pulse_width: got %0d extra cycles want 0", zeros); end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL dz_no_done: got %0d pulses want 0", dones); end
    n_cmp++; if (io.hi_out !== 32'd1) begin n_bad++; $display("FAIL dz_hi_held: got %h want 1", io.hi_out); end
    n_cmp++; if (io.lo_out !== 32'd3) begin n_bad++; $display("FAIL dz_lo_held: got %h want 3", io.lo_out); end
  endtask

  task automatic test_start_busy();
    int lat, bc, dones;
    logic [63:0] e;
    sb_q.push_back({32'd1, 32'd3});
    start_op(32'd7, 32'd2);
    repeat (5) @(negedge clk);
    io.div_start = 1'b1;
    io.dividend = 32'd100;
    io.divisor = 32'd10;
    @(negedge clk);
    io.div_start = 1'b0;
    wait_done(lat, bc);
    pop_exp(e);
    n_cmp++; if (lat !== 26) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 26", lat); end
    n_cmp++; if ({io.hi_out, io.lo_out} !== e) begin n_bad++; $display("FAIL busy_start_result: got %h want %h", {io.hi_out, io.lo_out}, e); end
    dones = 0;
    repeat (45) begin
      @(negedge clk);
      if (io.div_done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL busy_start_second_done: got %0d want 0", dones); end
    n_cmp++; if (io.busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle: got %b want 0", io.busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    logic [63:0] e;
    start_op(32'd7, 32'd2);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({io.hi_out, io.lo_out} !== 64'd0) begin n_bad++; $display("FAIL rmid_results: got %h want 0", {io.hi_out, io.lo_out}); end
    n_cmp++; if ({io.busy, io.div_done, io.div_zero} !== 3'b000) begin n_bad++; $display("FAIL rmid_flags: got %b want 000", {io.busy, io.div_done, io.div_zero}); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.div_done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
    sb_q.push_back({32'd2, 32'd14});
    start_op(32'd100, 32'd7);
    wait_done(lat, bc);
    pop_exp(e);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL rmid_after_latency: got %0d want 32", lat); end
    n_cmp++; if ({io.hi_out, io.lo_out} !== e) begin n_bad++; $display("FAIL rmid_after_result: got %h want %h", {io.hi_out, io.lo_out}, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int lat, bc;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom();
      if (i % 4 == 3) b = -b;
      if (b == 32'd0) b = 32'd1;
      sb_q.push_back(model(a, b));
      start_op(a, b);
      wait_done(lat, bc);
      pop_exp(e);
      n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want 32", i, lat); end
      n_cmp++; if ({io.hi_out, io.lo_out} !== e) begin n_bad++; $display("FAIL b2b_result[%0d] %h/%h: got %h want %h", i, a, b, {io.hi_out, io.lo_out}, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    io.div_start = 1'b0;
    io.dividend = '0;
    io.divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_signs();
    test_corners();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
